// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen
// Raster timing and test-pattern source for the HDMI TX pixel pins.
// A horizontal/vertical counter pair frames every picture, and a small pattern
// engine fills the active area. Pattern and colour are captured once per frame,
// so software writes never tear a picture. Every output is registered and
// reflects the counter state of the previous cycle.
module hdmi_video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   input  logic [23:0] i_color,
   output logic [23:0] o_tx_d,
   output logic        o_tx_de,
   output logic        o_tx_hs,
   output logic        o_tx_vs,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_frame_start,
   output logic        o_line_start,
   output logic        o_running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
   localparam logic        HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic        VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Colour of each of the eight vertical bars, left to right.
   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         3'd7:    c = 24'h000000;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [11:0] h_q, h_d;
   logic [11:0] v_q, v_d;
   logic [11:0] bar_cnt_q, bar_cnt_d;   // pixel position inside the current bar
   logic [2:0]  bar_idx_q, bar_idx_d;   // which bar the current pixel belongs to
   logic [1:0]  pat_q, pat_d;           // per-frame shadow of i_pattern
   logic [23:0] col_q, col_d;           // per-frame shadow of i_color

   logic [23:0] tx_d_q, tx_d_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        fs_q, fs_d;
   logic        ls_q, ls_d;
   logic        run_q, run_d;
   logic        run_s;

   // Timing state, raster counters, bar sub-counter and frame shadows.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         h_q       <= 12'd0;
         v_q       <= 12'd0;
         bar_cnt_q <= 12'd0;
         bar_idx_q <= 3'd0;
         pat_q     <= 2'd0;
         col_q     <= 24'd0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         v_q       <= v_d;
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
         pat_q     <= pat_d;
         col_q     <= col_d;
      end
   end

   // Next state: i_en only matters in IDLE and on the last pixel of a frame.
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
      pat_d     = pat_q;
      col_d     = col_q;
      case (state_q)
         ST_IDLE: begin
            h_d       = 12'd0;
            v_d       = 12'd0;
            bar_cnt_d = 12'd0;
            bar_idx_d = 3'd0;
            if (i_en) begin
               state_d = ST_RUN;
               pat_d   = i_pattern;
               col_d   = i_color;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (h_q == H_LAST) begin
               h_d       = 12'd0;
               bar_cnt_d = 12'd0;
               bar_idx_d = 3'd0;
               if (v_q == V_LAST) begin
                  v_d = 12'd0;
                  if (i_en) begin
                     state_d = ST_RUN;
                     pat_d   = i_pattern;
                     col_d   = i_color;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  v_d = v_q + 12'd1;
               end
            end else begin
               h_d = h_q + 12'd1;
               // Bars advance by counting pixels rather than dividing h.
               if (bar_cnt_q == BAR_LAST) begin
                  bar_cnt_d = 12'd0;
                  bar_idx_d = bar_idx_q + 3'd1;
               end else begin
                  bar_cnt_d = bar_cnt_q + 12'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the current counter state; IDLE yields reset levels.
   always_comb begin
      run_s  = (state_q == ST_RUN);
      de_d   = run_s && (h_q < H_ACT) && (v_q < V_ACT);
      hs_d   = (run_s && (h_q >= HS_BEG) && (h_q < HS_END)) ? HS_ACT : ~HS_ACT;
      vs_d   = (run_s && (v_q >= VS_BEG) && (v_q < VS_END)) ? VS_ACT : ~VS_ACT;
      x_d    = de_d ? h_q : 12'd0;
      y_d    = de_d ? v_q : 12'd0;
      fs_d   = de_d && (h_q == 12'd0) && (v_q == 12'd0);
      ls_d   = de_d && (h_q == 12'd0);
      run_d  = run_s;
      tx_d_d = 24'd0;
      if (de_d) begin
         case (pat_q)
            2'd0:    tx_d_d = col_q;
            2'd1:    tx_d_d = bar_color(bar_idx_q);
            2'd2:    tx_d_d = (h_q[3] ^ v_q[3]) ? 24'h000000 : 24'hFFFFFF;
            2'd3:    tx_d_d = {h_q[7:0], v_q[7:0], h_q[7:0] + v_q[7:0]};
            default: tx_d_d = 24'd0;
         endcase
      end else begin
         tx_d_d = 24'd0;
      end
   end

   // Output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         tx_d_q <= 24'd0;
         de_q   <= 1'b0;
         hs_q   <= ~HS_ACT;
         vs_q   <= ~VS_ACT;
         x_q    <= 12'd0;
         y_q    <= 12'd0;
         fs_q   <= 1'b0;
         ls_q   <= 1'b0;
         run_q  <= 1'b0;
      end else begin
         tx_d_q <= tx_d_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         x_q    <= x_d;
         y_q    <= y_d;
         fs_q   <= fs_d;
         ls_q   <= ls_d;
         run_q  <= run_d;
      end
   end

   assign o_tx_d        = tx_d_q;
   assign o_tx_de       = de_q;
   assign o_tx_hs       = hs_q;
   assign o_tx_vs       = vs_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_start = fs_q;
   assign o_line_start  = ls_q;
   assign o_running     = run_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Bench for hdmi_video_timing_gen: two instances (tiny raster, 640-wide raster)
// checked every cycle against a frame-position reference model, plus directed
// checks on latency, frame statistics, shadowing and pattern pixels.
module tb_hdmi_video_timing_gen;

   localparam int S_HA = 8,   S_HF = 2,  S_HS = 2,  S_HB = 2;
   localparam int S_VA = 4,   S_VF = 1,  S_VS = 1,  S_VB = 1;
   localparam int W_HA = 640, W_HF = 16, W_HS = 96, W_HB = 48;
   localparam int W_VA = 10,  W_VF = 1,  W_VS = 1,  W_VB = 1;
   localparam int W_FRAME = (W_HA + W_HF + W_HS + W_HB) * (W_VA + W_VF + W_VS + W_VB);

   typedef struct packed {
      logic [23:0] d;
      logic        de;
      logic        hs;
      logic        vs;
      logic [11:0] x;
      logic [11:0] y;
      logic        fs;
      logic        ls;
      logic        run;
   } vout_t;

   int cfg_ha [2] = '{S_HA, W_HA};
   int cfg_hf [2] = '{S_HF, W_HF};
   int cfg_hs [2] = '{S_HS, W_HS};
   int cfg_hb [2] = '{S_HB, W_HB};
   int cfg_va [2] = '{S_VA, W_VA};
   int cfg_vf [2] = '{S_VF, W_VF};
   int cfg_vs [2] = '{S_VS, W_VS};
   int cfg_vb [2] = '{S_VB, W_VB};
   logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        s_rst, s_en, w_rst, w_en;
   logic [1:0]  s_pat, w_pat;
   logic [23:0] s_col, w_col;
   logic [23:0] s_d, w_d;
   logic        s_de, s_hs, s_vs, s_fs, s_ls, s_run;
   logic        w_de, w_hs, w_vs, w_fs, w_ls, w_run;
   logic [11:0] s_x, s_y, w_x, w_y;
   vout_t       s_got, w_got;

   assign s_got = {s_d, s_de, s_hs, s_vs, s_x, s_y, s_fs, s_ls, s_run};
   assign w_got = {w_d, w_de, w_hs, w_vs, w_x, w_y, w_fs, w_ls, w_run};

   hdmi_video_timing_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .HS_POL(0), .VS_POL(0)
   ) u_small (
      .i_clk(clk), .i_rst(s_rst), .i_en(s_en), .i_pattern(s_pat), .i_color(s_col),
      .o_tx_d(s_d), .o_tx_de(s_de), .o_tx_hs(s_hs), .o_tx_vs(s_vs),
      .o_x(s_x), .o_y(s_y), .o_frame_start(s_fs), .o_line_start(s_ls), .o_running(s_run)
   );

   hdmi_video_timing_gen #(
      .H_ACTIVE(W_HA), .H_FP(W_HF), .H_SYNC(W_HS), .H_BP(W_HB),
      .V_ACTIVE(W_VA), .V_FP(W_VF), .V_SYNC(W_VS), .V_BP(W_VB),
      .HS_POL(0), .VS_POL(0)
   ) u_wide (
      .i_clk(clk), .i_rst(w_rst), .i_en(w_en), .i_pattern(w_pat), .i_color(w_col),
      .o_tx_d(w_d), .o_tx_de(w_de), .o_tx_hs(w_hs), .o_tx_vs(w_vs),
      .o_x(w_x), .o_y(w_y), .o_frame_start(w_fs), .o_line_start(w_ls), .o_running(w_run)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int frame_len(input int k);
      return (cfg_ha[k] + cfg_hf[k] + cfg_hs[k] + cfg_hb[k]) *
             (cfg_va[k] + cfg_vf[k] + cfg_vs[k] + cfg_vb[k]);
   endfunction

   function automatic logic [23:0] ref_pixel(input int k, input int x, input int y,
                                             input bit [1:0] pat, input bit [23:0] col);
      case (pat)
         2'd0:    return col;
         2'd1:    return bar_tbl[3'(x / (cfg_ha[k] / 8))];
         2'd2:    return (((x / 8) + (y / 8)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
         2'd3:    return {8'(x), 8'(y), 8'(x + y)};
         default: return 24'h0;
      endcase
   endfunction

   // Outputs expected for a given frame position t (cycles since frame start).
   function automatic vout_t expect_out(input int k, input bit run, input int t,
                                        input bit [1:0] pat, input bit [23:0] col);
      vout_t o;
      int htot, h, v;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      if (run) begin
         htot  = cfg_ha[k] + cfg_hf[k] + cfg_hs[k] + cfg_hb[k];
         h     = t % htot;
         v     = t / htot;
         o.run = 1'b1;
         o.hs  = !((h >= cfg_ha[k] + cfg_hf[k]) && (h < cfg_ha[k] + cfg_hf[k] + cfg_hs[k]));
         o.vs  = !((v >= cfg_va[k] + cfg_vf[k]) && (v < cfg_va[k] + cfg_vf[k] + cfg_vs[k]));
         if (h < cfg_ha[k] && v < cfg_va[k]) begin
            o.de = 1'b1;
            o.x  = 12'(h);
            o.y  = 12'(v);
            o.fs = (h == 0 && v == 0);
            o.ls = (h == 0);
            o.d  = ref_pixel(k, h, v, pat, col);
         end
      end
      return o;
   endfunction

   function automatic logic rst_of(input int k);
      return (k == 0) ? s_rst : w_rst;
   endfunction
   function automatic logic en_of(input int k);
      return (k == 0) ? s_en : w_en;
   endfunction
   function automatic logic [1:0] pat_of(input int k);
      return (k == 0) ? s_pat : w_pat;
   endfunction
   function automatic logic [23:0] col_of(input int k);
      return (k == 0) ? s_col : w_col;
   endfunction

   bit        m_run [2];
   int        m_t   [2];
   bit [1:0]  m_pat [2];
   bit [23:0] m_col [2];
   vout_t     m_exp [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_exp[k] <= expect_out(k, m_run[k], m_t[k], m_pat[k], m_col[k]);
         if (!rst_of(k)) begin
            m_exp[k] <= expect_out(k, 1'b0, 0, 2'd0, 24'd0);
            m_run[k] <= 1'b0;
            m_t[k]   <= 0;
            m_pat[k] <= 2'd0;
            m_col[k] <= 24'd0;
         end else if (!m_run[k]) begin
            if (en_of(k)) begin
               m_run[k] <= 1'b1;
               m_t[k]   <= 0;
               m_pat[k] <= pat_of(k);
               m_col[k] <= col_of(k);
            end
         end else if (m_t[k] == frame_len(k) - 1) begin
            m_t[k] <= 0;
            if (en_of(k)) begin
               m_pat[k] <= pat_of(k);
               m_col[k] <= col_of(k);
            end else begin
               m_run[k] <= 1'b0;
            end
         end else begin
            m_t[k] <= m_t[k] + 1;
         end
      end
   end

   task automatic cmp_out(input string p, input vout_t g, input vout_t e);
      check_eq({p, ".d"},   g.d,   e.d);
      check_eq({p, ".de"},  g.de,  e.de);
      check_eq({p, ".hs"},  g.hs,  e.hs);
      check_eq({p, ".vs"},  g.vs,  e.vs);
      check_eq({p, ".x"},   g.x,   e.x);
      check_eq({p, ".y"},   g.y,   e.y);
      check_eq({p, ".fs"},  g.fs,  e.fs);
      check_eq({p, ".ls"},  g.ls,  e.ls);
      check_eq({p, ".run"}, g.run, e.run);
   endtask

   always @(negedge clk) begin
      cmp_out("s", s_got, m_exp[0]);
      cmp_out("w", w_got, m_exp[1]);
   end

   // ---------------- directed sequences ----------------
   task automatic wait_fs(input int k, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((k == 0) ? s_fs : w_fs) && n < budget);
      check_eq(tag, (k == 0) ? s_fs : w_fs, 1'b1);
   endtask

   task automatic small_seq();
      int n, de_n, hs_n, vs_n, fs_n, bad, lx, ly;
      s_rst = 1'b0; s_en = 1'b1; s_pat = 2'd0; s_col = 24'h123456;
      repeat (5) @(negedge clk);
      check_eq("rst_de", s_de, 1'b0);
      check_eq("rst_hs", s_hs, 1'b1);
      check_eq("rst_vs", s_vs, 1'b1);
      check_eq("rst_d", s_d, 24'd0);
      check_eq("rst_run", s_run, 1'b0);
      s_rst = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_fs && n < 10);
      check_eq("fs_latency", n, 2);
      de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
      for (int i = 0; i < 98; i++) begin
         if (i > 0) @(negedge clk);
         de_n += int'(s_de);
         hs_n += int'(!s_hs);
         vs_n += int'(!s_vs);
         fs_n += int'(s_fs);
      end
      @(negedge clk);
      check_eq("fs_period", s_fs, 1'b1);
      check_eq("de_count", de_n, 32);
      check_eq("hs_low_count", hs_n, 14);
      check_eq("vs_low_count", vs_n, 14);
      check_eq("fs_count", fs_n, 1);
      // Colour written mid-frame must wait for the next frame.
      repeat (20) @(negedge clk);
      s_col = 24'hABCDEF;
      bad = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!s_fs && s_de && s_d != 24'h123456) bad++;
         if (!s_de && s_d != 24'd0) bad++;
      end while (!s_fs && n < 120);
      check_eq("col_hold", bad, 0);
      check_eq("col_new", s_d, 24'hABCDEF);
      s_pat = 2'd3;
      wait_fs(0, 120, "fs_grad");
      n = 0;
      while (!(s_de && s_x == 12'd5 && s_y == 12'd2) && n < 100) begin @(negedge clk); n++; end
      check_eq("grad_5_2", s_d, 24'h050207);
      // Dropping i_en mid-frame lets the frame finish, then stops.
      wait_fs(0, 120, "fs_drop");
      repeat (40) @(negedge clk);
      s_en = 1'b0;
      lx = -1; ly = -1; fs_n = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (s_de) begin lx = int'(s_x); ly = int'(s_y); end
         if (s_fs) fs_n++;
      end while (s_run && n < 150);
      repeat (10) begin @(negedge clk); if (s_fs) fs_n++; end
      check_eq("drop_run", s_run, 1'b0);
      check_eq("drop_last_x", lx, 7);
      check_eq("drop_last_y", ly, 3);
      check_eq("drop_no_fs", fs_n, 0);
      // Reset in the middle of a frame.
      s_en = 1'b1;
      wait_fs(0, 20, "fs_restart");
      repeat (30) @(negedge clk);
      check_eq("pre_rst_de", s_de, 1'b1);
      s_rst = 1'b0;
      @(negedge clk);
      cmp_out("mid_rst", s_got, '{d: 24'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, x: 12'd0,
                                  y: 12'd0, fs: 1'b0, ls: 1'b0, run: 1'b0});
      s_rst = 1'b1;
      // Random traffic, including occasional resets.
      for (int i = 0; i < 40; i++) begin
         s_pat = 2'($urandom);
         s_col = 24'($urandom);
         s_en  = ($urandom_range(0, 3) != 0);
         s_rst = ($urandom_range(0, 9) != 0);
         repeat ($urandom_range(1, 60)) @(negedge clk);
      end
      s_rst = 1'b1;
      s_en  = 1'b0;
   endtask

   task automatic wide_seq();
      int hits;
      logic [23:0] rc;
      w_rst = 1'b0; w_en = 1'b0; w_pat = 2'd1; w_col = 24'($urandom);
      repeat (3) @(negedge clk);
      w_rst = 1'b1; w_en = 1'b1;
      wait_fs(1, 10, "w_fs_first");
      // Colour bars frame.
      w_pat = 2'd2;
      hits = 0;
      for (int n = 0; n < W_FRAME + 5; n++) begin
         if (w_de && w_y == 12'd0 && (int'(w_x) % 80) == 0) begin
            check_eq($sformatf("bar_x%0d", w_x), w_d, bar_tbl[3'(int'(w_x) / 80)]);
            hits++;
         end
         if (w_de && w_y == 12'd0 && w_x == 12'd559) check_eq("bar_edge559", w_d, 24'h0000FF);
         @(negedge clk);
         if (w_fs) break;
      end
      check_eq("bar_hits", hits, 8);
      check_eq("w_fs_chk", w_fs, 1'b1);
      // Checker frame.
      w_pat = 2'd3;
      hits = 0;
      for (int n = 0; n < W_FRAME + 5; n++) begin
         if (w_de && w_x == 12'd0 && w_y == 12'd0) begin check_eq("chk_0_0", w_d, 24'hFFFFFF); hits++; end
         if (w_de && w_x == 12'd8 && w_y == 12'd0) begin check_eq("chk_8_0", w_d, 24'h000000); hits++; end
         if (w_de && w_x == 12'd8 && w_y == 12'd8) begin check_eq("chk_8_8", w_d, 24'hFFFFFF); hits++; end
         @(negedge clk);
         if (w_fs) break;
      end
      check_eq("chk_hits", hits, 3);
      check_eq("w_fs_grad", w_fs, 1'b1);
      // Gradient frame; x beyond 255 exercises the modulo wrap.
      rc = 24'($urandom);
      w_pat = 2'd0;
      w_col = rc;
      hits = 0;
      for (int n = 0; n < W_FRAME + 5; n++) begin
         if (w_de && w_x == 12'd300 && w_y == 12'd5) begin check_eq("grad_300_5", w_d, 24'h2C0531); hits++; end
         if (w_de && w_x == 12'd5 && w_y == 12'd2) begin check_eq("grad_5_2w", w_d, 24'h050207); hits++; end
         @(negedge clk);
         if (w_fs) break;
      end
      check_eq("grad_hits", hits, 2);
      check_eq("w_fs_solid", w_fs, 1'b1);
      check_eq("solid_px0", w_d, rc);
      w_en = 1'b0;
      for (int n = 0; n < W_FRAME + 10; n++) begin
         @(negedge clk);
         if (!w_run) break;
      end
      check_eq("w_stop", w_run, 1'b0);
   endtask

   initial begin
      fork
         small_seq();
         wide_seq();
      join
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
